// File: rtl/game_pkg.sv
// Shared types and defaults for the 2048-style game controller.
// Holds FSM state codes, move codes and default timing constants.
package game_pkg;

    localparam int DEBOUNCE_DEFAULT = 500000;
    localparam int TIMEOUT_DEFAULT  = 1000000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_EXEC  = 3'd2,
        ST_SPAWN = 3'd3,
        ST_CHECK = 3'd4,
        ST_WON   = 3'd5,
        ST_LOST  = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        MOV_NONE      = 3'd0,
        MOV_IZQUIERDA = 3'd1,
        MOV_DERECHA   = 3'd2,
        MOV_ARRIBA    = 3'd3,
        MOV_ABAJO     = 3'd4
    } move_t;

    // Press vector bit order: 0 izquierda, 1 derecha, 2 arriba, 3 abajo.
    // Lower bit wins when several edges land on the same cycle.
    function automatic move_t pick_move(logic [3:0] fell);
        move_t m;
        if (fell[0])      m = MOV_IZQUIERDA;
        else if (fell[1]) m = MOV_DERECHA;
        else if (fell[2]) m = MOV_ARRIBA;
        else if (fell[3]) m = MOV_ABAJO;
        else              m = MOV_NONE;
        return m;
    endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Board-datapath side of the game controller: move handshake,
// spawn request and board status.
interface game_ctrl_if;
    import game_pkg::*;

    logic  move_valid;
    move_t move_dir;
    logic  move_ready;
    logic  move_done;
    logic  board_changed;
    logic  spawn_req;
    logic  spawn_done;
    logic  win;
    logic  lose;

    modport master (
        output move_valid, move_dir, spawn_req,
        input  move_ready, move_done, board_changed,
        input  spawn_done, win, lose
    );

    modport slave (
        input  move_valid, move_dir, spawn_req,
        output move_ready, move_done, board_changed,
        output spawn_done, win, lose
    );

endinterface

// File: rtl/btn_debounce.sv
// Active-low button conditioner: 2-flop synchronizer, stability
// counter, accepted level, and a one-cycle press (1->0) pulse.
module btn_debounce
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic fell
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    // Accept a new level only after it differs for DEBOUNCE_CYCLES in a row.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            fell  <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            fell  <= 1'b0;
            if (sync2 != level) begin
                if (cnt == LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                    fell  <= ~sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Game controller: debounced buttons -> move command -> spawn -> check.
// Optional watchdog enabled by defining GAME_CTRL_WATCHDOG_EN.
module game_ctrl
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int TIMEOUT_CYCLES  = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_izquierda,
    input  logic        btn_derecha,
    input  logic        btn_arriba,
    input  logic        btn_abajo,
    game_ctrl_if.master bus,
    output logic [2:0]  game_state,
    output logic        busy,
    output logic        timeout_err
);

    state_t     state_q;
    state_t     state_d;
    move_t      dir_q;
    move_t      dir_d;
    logic [3:0] btn_raw;
    logic [3:0] fell;
    logic       wd_hit;

    assign btn_raw = {btn_abajo, btn_arriba, btn_derecha, btn_izquierda};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn_raw[i]),
            .fell (fell[i])
        );
    end

`ifdef GAME_CTRL_WATCHDOG_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] wd_q;
    logic          wd_run;
    logic          tmo_q;

    assign wd_run = (state_q == ST_ISSUE) || (state_q == ST_EXEC) ||
                    (state_q == ST_SPAWN);
    assign wd_hit = wd_run && (wd_q == WD_LAST);

    // Per-state cycle counter; restarts whenever the state changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q  <= '0;
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= wd_hit;
            if (state_d != state_q) wd_q <= '0;
            else if (wd_run)        wd_q <= wd_q + 1'b1;
        end
    end

    assign timeout_err = tmo_q;
`else
    // No watchdog: the FSM waits indefinitely for the datapath.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("game_ctrl: TIMEOUT_CYCLES must be positive");
    end

    assign wd_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State and latched move code.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= MOV_NONE;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
        end
    end

    // Next state; press edges outside IDLE simply fall through unused.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|fell) begin
                    state_d = ST_ISSUE;
                    dir_d   = pick_move(fell);
                end
            end
            ST_ISSUE: begin
                if (bus.move_ready) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (bus.move_done) begin
                    if (bus.board_changed) begin
                        state_d = ST_SPAWN;
                    end else begin
                        state_d = ST_IDLE;
                        dir_d   = MOV_NONE;
                    end
                end
            end
            ST_SPAWN: begin
                if (bus.spawn_done) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (bus.win) begin
                    state_d = ST_WON;
                end else if (bus.lose) begin
                    state_d = ST_LOST;
                end else begin
                    state_d = ST_IDLE;
                    dir_d   = MOV_NONE;
                end
            end
            ST_WON, ST_LOST: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_IDLE;
                dir_d   = MOV_NONE;
            end
        endcase
        if (wd_hit) begin
            state_d = ST_IDLE;
            dir_d   = MOV_NONE;
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        bus.move_valid = (state_q == ST_ISSUE);
        bus.spawn_req  = (state_q == ST_SPAWN);
        bus.move_dir   = dir_q;
        busy           = (state_q != ST_IDLE);
        game_state     = state_q;
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Randomized self-checking bench for game_ctrl.
// Define GAME_CTRL_WATCHDOG_EN to exercise the watchdog build.
module tb_game_ctrl;

    localparam int DEB = 4;
    localparam int TMO = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_n = 4'hF;
    logic [2:0] game_state;
    logic       busy;
    logic       timeout_err;

    int checks = 0;
    int failures = 0;

    game_ctrl_if bus();

    game_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_izquierda(btn_n[0]),
        .btn_derecha  (btn_n[1]),
        .btn_arriba   (btn_n[2]),
        .btn_abajo    (btn_n[3]),
        .bus          (bus),
        .game_state   (game_state),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    // Reference: move code chosen by button priority list.
    function automatic int exp_move(logic [3:0] mask);
        int order [4] = '{1, 2, 3, 4};
        for (int i = 0; i < 4; i++)
            if (mask[i]) return order[i];
        return 0;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic press(input logic [3:0] mask);
        btn_n = btn_n & ~mask;
    endtask

    task automatic release_all();
        btn_n = 4'hF;
    endtask

    task automatic wait_valid(input int bound, output int lat);
        lat = -1;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (bus.move_valid === 1'b1) begin
                lat = i + 1;
                return;
            end
        end
    endtask

    task automatic pulse_done(input logic bc);
        bus.move_done = 1'b1;
        bus.board_changed = bc;
        tick();
        bus.move_done = 1'b0;
        bus.board_changed = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (game_state !== 3'd0 || bus.move_valid !== 1'b0 ||
            bus.move_dir !== 3'd0 || bus.spawn_req !== 1'b0 ||
            busy !== 1'b0 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL reset: st=%0d v=%b d=%0d sp=%b b=%b t=%b req 0",
                     game_state, bus.move_valid, bus.move_dir,
                     bus.spawn_req, busy, timeout_err);
        end
    endtask

    task automatic test_single_move();
        int lat;
        int vcnt;
        logic sp_seen;
        bus.move_ready = 1'b1;
        press(4'b0010);
        wait_valid(DEB + 10, lat);
        checks++;
        if (lat < DEB + 1 || lat > DEB + 4) begin
            failures++;
            $display("FAIL single_lat: lat=%0d req %0d..%0d",
                     lat, DEB + 1, DEB + 4);
        end
        checks++;
        if (bus.move_dir !== 3'd2) begin
            failures++;
            $display("FAIL single_dir: dir=%0d req 2", bus.move_dir);
        end
        vcnt = 1;
        tick();
        if (bus.move_valid === 1'b1) vcnt++;
        checks++;
        if (vcnt != 1 || game_state !== 3'd2) begin
            failures++;
            $display("FAIL single_exec: vcycles=%0d st=%0d req 1,2",
                     vcnt, game_state);
        end
        bus.move_ready = 1'b0;
        sp_seen = 1'b0;
        pulse_done(1'b0);
        if (bus.spawn_req === 1'b1) sp_seen = 1'b1;
        checks++;
        if (game_state !== 3'd0 || bus.move_dir !== 3'd0) begin
            failures++;
            $display("FAIL nochange: st=%0d dir=%0d req 0,0",
                     game_state, bus.move_dir);
        end
        vcnt = 0;
        for (int i = 0; i < 3 * DEB; i++) begin
            tick();
            if (bus.move_valid === 1'b1) vcnt++;
            if (bus.spawn_req === 1'b1) sp_seen = 1'b1;
        end
        release_all();
        for (int i = 0; i < 2 * DEB + 4; i++) begin
            tick();
            if (bus.move_valid === 1'b1) vcnt++;
        end
        checks++;
        if (vcnt != 0 || sp_seen) begin
            failures++;
            $display("FAIL held_retrigger: v=%0d spawn=%b req 0,0",
                     vcnt, sp_seen);
        end
    endtask

    task automatic test_priority_discard();
        int lat;
        int vcnt;
        bus.move_ready = 1'b1;
        press(4'b1001);
        wait_valid(DEB + 10, lat);
        checks++;
        if (lat < 0 || bus.move_dir !== 3'd1) begin
            failures++;
            $display("FAIL prio: lat=%0d dir=%0d req 1", lat, bus.move_dir);
        end
        tick();
        bus.move_ready = 1'b0;
        press(4'b0100);
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (game_state !== 3'd2) begin
            failures++;
            $display("FAIL exec_hold: st=%0d req 2", game_state);
        end
        release_all();
        pulse_done(1'b0);
        vcnt = 0;
        for (int i = 0; i < 3 * DEB + 10; i++) begin
            tick();
            if (bus.move_valid === 1'b1) vcnt++;
        end
        checks++;
        if (vcnt != 0 || game_state !== 3'd0) begin
            failures++;
            $display("FAIL discard: v=%0d st=%0d req 0,0", vcnt, game_state);
        end
    endtask

    task automatic test_random_moves();
        for (int it = 0; it < 10; it++) begin
            logic [3:0] mask;
            int lat;
            int want;
            int rd;
            logic bc;
            logic ls;
            int vcnt;
            mask = 4'($urandom_range(1, 15));
            want = exp_move(mask);
            rd = $urandom_range(0, 3);
            bus.move_ready = 1'b0;
            press(mask);
            wait_valid(DEB + 10, lat);
            checks++;
            if (lat < 0 || bus.move_dir !== 3'(want)) begin
                failures++;
                $display("FAIL rnd_dir it=%0d: lat=%0d dir=%0d req %0d",
                         it, lat, bus.move_dir, want);
            end
            for (int d = 0; d < rd; d++) begin
                tick();
                checks++;
                if (bus.move_valid !== 1'b1 || bus.move_dir !== 3'(want)) begin
                    failures++;
                    $display("FAIL rnd_stall it=%0d: v=%b dir=%0d req 1,%0d",
                             it, bus.move_valid, bus.move_dir, want);
                end
            end
            bus.move_ready = 1'b1;
            tick();
            bus.move_ready = 1'b0;
            checks++;
            if (bus.move_valid !== 1'b0 || game_state !== 3'd2) begin
                failures++;
                $display("FAIL rnd_xfer it=%0d: v=%b st=%0d req 0,2",
                         it, bus.move_valid, game_state);
            end
            bus.spawn_done = 1'b1;
            tick();
            bus.spawn_done = 1'b0;
            if ($urandom_range(0, 1) == 1) release_all();
            for (int e = $urandom_range(0, 3); e > 0; e--) tick();
            checks++;
            if (game_state !== 3'd2) begin
                failures++;
                $display("FAIL rnd_stray it=%0d: st=%0d req 2",
                         it, game_state);
            end
            bc = 1'($urandom_range(0, 1));
            pulse_done(bc);
            if (!bc) begin
                checks++;
                if (game_state !== 3'd0 || bus.spawn_req !== 1'b0 ||
                    bus.move_dir !== 3'd0) begin
                    failures++;
                    $display("FAIL rnd_idle it=%0d: st=%0d sp=%b req 0,0",
                             it, game_state, bus.spawn_req);
                end
            end else begin
                for (int s = $urandom_range(0, 3); s >= 0; s--) begin
                    checks++;
                    if (game_state !== 3'd3 || bus.spawn_req !== 1'b1) begin
                        failures++;
                        $display("FAIL rnd_spawn it=%0d: st=%0d sp=%b req 3,1",
                                 it, game_state, bus.spawn_req);
                    end
                    if (s > 0) tick();
                end
                ls = ($urandom_range(0, 3) == 0);
                bus.spawn_done = 1'b1;
                tick();
                bus.spawn_done = 1'b0;
                bus.win = 1'b0;
                bus.lose = ls;
                checks++;
                if (game_state !== 3'd4 || bus.spawn_req !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_check it=%0d: st=%0d sp=%b req 4,0",
                             it, game_state, bus.spawn_req);
                end
                tick();
                bus.lose = 1'b0;
                checks++;
                if (game_state !== (ls ? 3'd6 : 3'd0)) begin
                    failures++;
                    $display("FAIL rnd_result it=%0d: st=%0d req %0d",
                             it, game_state, ls ? 6 : 0);
                end
                if (ls) do_reset();
            end
            release_all();
            vcnt = 0;
            for (int i = 0; i < 2 * DEB + 4; i++) begin
                tick();
                if (bus.move_valid === 1'b1) vcnt++;
            end
            checks++;
            if (vcnt != 0) begin
                failures++;
                $display("FAIL rnd_quiet it=%0d: v=%0d req 0", it, vcnt);
            end
        end
    endtask

    task automatic test_win_terminal();
        int lat;
        int vcnt;
        bus.move_ready = 1'b1;
        press(4'b0010);
        wait_valid(DEB + 10, lat);
        tick();
        bus.move_ready = 1'b0;
        release_all();
        pulse_done(1'b1);
        bus.spawn_done = 1'b1;
        tick();
        bus.spawn_done = 1'b0;
        bus.win = 1'b1;
        bus.lose = 1'b1;
        tick();
        bus.win = 1'b0;
        bus.lose = 1'b0;
        checks++;
        if (lat < 0 || game_state !== 3'd5) begin
            failures++;
            $display("FAIL win_prio: lat=%0d st=%0d req 5", lat, game_state);
        end
        vcnt = 0;
        bus.move_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            press(4'($urandom_range(1, 15)));
            for (int i = 0; i < DEB + 6; i++) begin
                tick();
                if (bus.move_valid === 1'b1) vcnt++;
            end
            release_all();
            for (int i = 0; i < DEB + 4; i++) tick();
        end
        bus.move_ready = 1'b0;
        checks++;
        if (vcnt != 0 || game_state !== 3'd5 || busy !== 1'b1) begin
            failures++;
            $display("FAIL won_term: v=%0d st=%0d b=%b req 0,5,1",
                     vcnt, game_state, busy);
        end
        do_reset();
        checks++;
        if (game_state !== 3'd0) begin
            failures++;
            $display("FAIL won_rst: st=%0d req 0", game_state);
        end
    endtask

    task automatic test_glitch();
        int vcnt;
        bus.move_ready = 1'b1;
        press(4'b0100);
        for (int i = 0; i < 3; i++) tick();
        release_all();
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.move_valid === 1'b1) vcnt++;
        end
        bus.move_ready = 1'b0;
        checks++;
        if (vcnt != 0 || game_state !== 3'd0) begin
            failures++;
            $display("FAIL glitch: v=%0d st=%0d req 0,0", vcnt, game_state);
        end
    endtask

    task automatic test_stray_pulses();
        bus.move_done = 1'b1;
        bus.board_changed = 1'b1;
        bus.spawn_done = 1'b1;
        tick();
        tick();
        bus.move_done = 1'b0;
        bus.board_changed = 1'b0;
        bus.spawn_done = 1'b0;
        checks++;
        if (game_state !== 3'd0 || bus.spawn_req !== 1'b0) begin
            failures++;
            $display("FAIL stray: st=%0d sp=%b req 0,0",
                     game_state, bus.spawn_req);
        end
    endtask

    task automatic test_rst_in_issue();
        int lat;
        int vcnt;
        bus.move_ready = 1'b0;
        press(4'b0001);
        wait_valid(DEB + 10, lat);
        tick();
        release_all();
        rst = 1'b1;
        tick();
        checks++;
        if (lat < 0 || bus.move_valid !== 1'b0 || game_state !== 3'd0 ||
            bus.move_dir !== 3'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_issue: lat=%0d v=%b st=%0d d=%0d req -,0,0,0",
                     lat, bus.move_valid, game_state, bus.move_dir);
        end
        rst = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 2 * DEB + 6; i++) begin
            tick();
            if (bus.move_valid === 1'b1) vcnt++;
        end
        checks++;
        if (vcnt != 0) begin
            failures++;
            $display("FAIL rst_quiet: v=%0d req 0", vcnt);
        end
    endtask

    task automatic test_watchdog();
        int lat;
        int pulses;
        int first;
        bus.move_ready = 1'b1;
        press(4'b1000);
        wait_valid(DEB + 10, lat);
        tick();
        bus.move_ready = 1'b0;
        release_all();
        pulses = 0;
        first = -1;
        for (int i = 1; i <= TMO + 10; i++) begin
            tick();
            if (timeout_err === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
`ifdef GAME_CTRL_WATCHDOG_EN
        checks++;
        if (pulses != 1 || first < TMO - 2 || first > TMO + 1 ||
            game_state !== 3'd0 || bus.move_dir !== 3'd0) begin
            failures++;
            $display("FAIL wdog: pulses=%0d at=%0d st=%0d req 1,~%0d,0",
                     pulses, first, game_state, TMO);
        end
`else
        checks++;
        if (lat < 0 || pulses != 0 || game_state !== 3'd2) begin
            failures++;
            $display("FAIL no_wdog: pulses=%0d st=%0d req 0,2",
                     pulses, game_state);
        end
        pulse_done(1'b0);
`endif
        for (int i = 0; i < DEB + 4; i++) tick();
        checks++;
        if (game_state !== 3'd0 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL wdog_after: st=%0d t=%b req 0,0",
                     game_state, timeout_err);
        end
    endtask

    initial begin
        bus.move_ready = 1'b0;
        bus.move_done = 1'b0;
        bus.board_changed = 1'b0;
        bus.spawn_done = 1'b0;
        bus.win = 1'b0;
        bus.lose = 1'b0;
        test_reset();
        test_single_move();
        test_priority_discard();
        test_stray_pulses();
        test_random_moves();
        test_glitch();
        test_rst_in_issue();
        test_watchdog();
        test_win_terminal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
